// File: rtl/ram_test_pkg.sv
// Shared types and helpers for the RAM pattern write/verify blocks.
package ram_test_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Callers truncate the 32-bit result to their data width, giving the mod 2**DATA_W wrap.
  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
    return addr + seed;
  endfunction

endpackage

// File: rtl/ram_pattern_writer_rd_tag_pipe.sv
// Valid+address shift register that tracks RAM reads in flight for a given read latency.
module rd_tag_pipe #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              pending_o
);

  logic [LATENCY-1:0] vld_q;
  logic [ADDR_W-1:0]  addr_q [LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[LATENCY-1];
  assign addr_o = addr_q[LATENCY-1];

  // Tags that will still be in flight after the next edge (all stages except the output one).
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) pending_o = pending_o | vld_q[i];
  end

endmodule

// File: rtl/ram_pattern_writer.sv
// Fills an external RAM with a seeded address pattern through port A, then
// reads it back through port B and reports error count and first failing address.
module ram_pattern_writer
  import ram_test_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] SEED       = '0
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** ADDR_W) - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic [ADDR_W:0]   errCnt_q, errCnt_d;
  logic [ADDR_W-1:0] firstErr_q, firstErr_d;
  logic              pass_q, pass_d;

  logic              tagVld;
  logic [ADDR_W-1:0] tagAddr;
  logic              tagPending;
  logic              mismatch;
  logic              startOk;

  rd_tag_pipe #(
    .LATENCY(RD_LATENCY),
    .ADDR_W (ADDR_W)
  ) u_tag_pipe (
    .clk_i    (sys_clk),
    .rst_i    (rst),
    .vld_i    (state_q == READ),
    .addr_i   (rdAddr_q),
    .vld_o    (tagVld),
    .addr_o   (tagAddr),
    .pending_o(tagPending)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign startOk = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WRITE;
      WRITE:   if (wrAddr_q == LAST_ADDR) state_d = READ;
      READ:    if (rdAddr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   if (!tagPending) state_d = DONE;
      DONE:    if (start) state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wea  = (state_q == WRITE);
    busy = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  assign mismatch = doutb != DATA_W'(pattern(32'(tagAddr), 32'(SEED)));

  // Counters wrap to 0 on the last address, so each run starts from 0 without an explicit clear.
  always_comb begin
    wrAddr_d   = (state_q == WRITE) ? wrAddr_q + 1'b1 : wrAddr_q;
    rdAddr_d   = (state_q == READ)  ? rdAddr_q + 1'b1 : rdAddr_q;
    errCnt_d   = errCnt_q;
    firstErr_d = firstErr_q;
    pass_d     = pass_q;
    if (startOk) begin
      errCnt_d   = '0;
      firstErr_d = '0;
      pass_d     = 1'b0;
    end else begin
      if (busy && tagVld && mismatch) begin
        if (errCnt_q == '0) firstErr_d = tagAddr;
        if (errCnt_q != '1) errCnt_d = errCnt_q + 1'b1;
      end
      if ((state_q == DRAIN) && (state_d == DONE)) pass_d = (errCnt_d == '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wrAddr_q   <= '0;
      rdAddr_q   <= '0;
      errCnt_q   <= '0;
      firstErr_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      wrAddr_q   <= wrAddr_d;
      rdAddr_q   <= rdAddr_d;
      errCnt_q   <= errCnt_d;
      firstErr_q <= firstErr_d;
      pass_q     <= pass_d;
    end
  end

  assign addra          = wrAddr_q;
  assign dina           = wea ? DATA_W'(pattern(32'(wrAddr_q), 32'(SEED))) : '0;
  assign addrb          = rdAddr_q;
  assign pass           = pass_q;
  assign err_cnt        = errCnt_q;
  assign first_err_addr = firstErr_q;

endmodule

// File: tb/tb_ram_pattern_writer.sv
// Directed bench: two instances (latency 1 / seed 0 and latency 2 / seed F0) each on its own RAM model.
module tb_ram_pattern_writer;

  logic       sys_clk;
  logic       rst;
  logic       start;

  logic       wea1, busy1, done1, pass1;
  logic [4:0] addra1, addrb1, firstErr1;
  logic [7:0] dina1, doutb1;
  logic [5:0] errCnt1;

  logic       wea2, busy2, done2, pass2;
  logic [4:0] addra2, addrb2, firstErr2;
  logic [7:0] dina2, doutb2, rd2Stage;
  logic [5:0] errCnt2;

  logic [7:0] mem1 [32];
  logic [7:0] mem2 [32];
  logic [7:0] orMask1 [32];
  logic [7:0] xorMask1 [32];

  int checkCount = 0;
  int passCount  = 0;

  int         done1Cyc, done2Cyc, wea1Cnt, dina1Bad;
  logic [7:0] dina2At0, dina2At16;
  logic       done1AtC1, busy1AtC1;
  logic [5:0] err1AtC1;

  ram_pattern_writer dut1 (
    .sys_clk(sys_clk), .rst(rst), .start(start),
    .wea(wea1), .addra(addra1), .dina(dina1), .addrb(addrb1), .doutb(doutb1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(errCnt1), .first_err_addr(firstErr1)
  );

  ram_pattern_writer #(.RD_LATENCY(2), .SEED(8'hF0)) dut2 (
    .sys_clk(sys_clk), .rst(rst), .start(start),
    .wea(wea2), .addra(addra2), .dina(dina2), .addrb(addrb2), .doutb(doutb2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(errCnt2), .first_err_addr(firstErr2)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Behavioural RAMs; the first one can inject stuck-at and bit-flip faults on read data.
  always @(posedge sys_clk) begin
    if (wea1) mem1[addra1] <= dina1;
    doutb1 <= (mem1[addrb1] | orMask1[addrb1]) ^ xorMask1[addrb1];
    if (wea2) mem2[addra2] <= dina2;
    rd2Stage <= mem2[addrb2];
    doutb2   <= rd2Stage;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Pulses start (edge 0 is the next rising edge) and records cycle-numbered observations.
  task automatic applyStimulus(input int pulseCycle, input int rstCycle);
    done1Cyc = 0; done2Cyc = 0; wea1Cnt = 0; dina1Bad = 0;
    dina2At0 = 8'hxx; dina2At16 = 8'hxx;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      if (cyc == 1) begin
        done1AtC1 = done1; busy1AtC1 = busy1; err1AtC1 = errCnt1;
      end
      if (wea1) begin
        wea1Cnt++;
        if (dina1 != {3'b000, addra1}) dina1Bad++;
      end
      if (wea2 && addra2 == 5'd0)  dina2At0  = dina2;
      if (wea2 && addra2 == 5'd16) dina2At16 = dina2;
      if (done1 && done1Cyc == 0) done1Cyc = cyc;
      if (done2 && done2Cyc == 0) done2Cyc = cyc;
      if (rstCycle != 0 && cyc == rstCycle) begin
        rst = 1'b1;
        break;
      end
      if (done1Cyc != 0 && done2Cyc != 0) break;
      start = (cyc == pulseCycle);
      @(posedge sys_clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      orMask1[i] = 8'h00; xorMask1[i] = 8'h00;
      mem1[i] = 8'h00; mem2[i] = 8'h00;
    end
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("rst_ctrl1", {wea1, busy1, done1, pass1}, 4'b0000);
    checkOutput("rst_addr1", {addra1, addrb1, firstErr1}, 15'd0);
    checkOutput("rst_data1", {dina1, 2'b00, errCnt1}, 16'd0);
    checkOutput("rst_dina2", {dina2, wea2, done2}, 10'd0);
    rst = 1'b0;
    @(posedge sys_clk); #1;

    $display("[TB] clean run");
    applyStimulus(0, 0);
    checkOutput("wea_cycles", wea1Cnt, 32);
    checkOutput("dina_eq_addr", dina1Bad, 0);
    checkOutput("done_cycle_l1", done1Cyc, 66);
    checkOutput("result_l1", {pass1, errCnt1, firstErr1}, {1'b1, 6'd0, 5'd0});
    checkOutput("done_cycle_l2", done2Cyc, 67);
    checkOutput("pass_l2", {pass2, errCnt2}, {1'b1, 6'd0});
    checkOutput("seed_dina_a0", dina2At0, 8'hF0);
    checkOutput("seed_dina_a16", dina2At16, 8'h00);

    $display("[TB] stuck bit3 at address 5");
    orMask1[5] = 8'h08;
    applyStimulus(0, 0);
    checkOutput("stuck_err", errCnt1, 6'd1);
    checkOutput("stuck_first", firstErr1, 5'd5);
    checkOutput("stuck_pass", pass1, 1'b0);
    orMask1[5] = 8'h00;

    $display("[TB] flips at addresses 7 and 20");
    xorMask1[7] = 8'h01; xorMask1[20] = 8'h80;
    applyStimulus(0, 0);
    checkOutput("two_err", errCnt1, 6'd2);
    checkOutput("two_first", firstErr1, 5'd7);
    checkOutput("two_pass_l2", pass2, 1'b1);
    xorMask1[7] = 8'h00; xorMask1[20] = 8'h00;

    $display("[TB] rerun from DONE clears results");
    applyStimulus(0, 0);
    checkOutput("rerun_c1", {done1AtC1, busy1AtC1, err1AtC1}, {1'b0, 1'b1, 6'd0});
    checkOutput("rerun_done", done1Cyc, 66);
    checkOutput("rerun_result", {pass1, errCnt1, firstErr1}, {1'b1, 6'd0, 5'd0});

    $display("[TB] start pulsed during WRITE");
    applyStimulus(10, 0);
    checkOutput("ignore_done", done1Cyc, 66);
    repeat (10) @(posedge sys_clk);
    #1;
    checkOutput("ignore_hold", {done1, busy1, pass1}, 3'b101);

    $display("[TB] reset during READ");
    applyStimulus(0, 40);
    @(posedge sys_clk); #1;
    checkOutput("midrst_ctrl", {wea1, busy1, done1, pass1, busy2}, 5'b00000);
    checkOutput("midrst_addr", {addra1, addrb1, firstErr1, errCnt1, dina1}, 29'd0);
    rst = 1'b0;
    @(posedge sys_clk); #1;
    applyStimulus(0, 0);
    checkOutput("after_rst_done", done1Cyc, 66);
    checkOutput("after_rst_pass", {pass1, errCnt1, pass2}, {1'b1, 6'd0, 1'b1});

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
